// File: rtl/arb_pkg.sv
// Shared constants and types for the four-way memory port arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: the first set request after `last`, wrapping back to `last` itself.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    output logic [1:0]         pick,
    output logic               any
);

    // Scan from the lowest priority up so the highest-priority hit is written last.
    always_comb begin
        logic [1:0] cand;
        cand = 2'd0;
        pick = 2'd0;
        any  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = last + 2'(k);
            if (req[cand]) begin
                pick = cand;
                any  = 1'b1;
            end else begin
                any  = any;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of a single shared memory port, with completion/timeout handling
// and a one-cycle acknowledge back to the winning requester.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic [1:0]                grant,
    output logic                      grant_valid,
    output logic                      mem_valid,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ready,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t        state_q, state_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0]        pick_s;
    logic              any_s;

    rr_pick4 u_pick (
        .req  (req),
        .last (last_q),
        .pick (pick_s),
        .any  (any_s)
    );

    // Next-state logic; the final BUSY cycle gives mem_ready precedence over the timeout.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (any_s) begin
                    grant_d = pick_s;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ARB_BUSY;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (mem_ready) begin
                    rdata_d = mem_rdata;
                    err_d   = 1'b0;
                    state_d = ARB_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = {DATA_W{1'b0}};
                    err_d   = 1'b1;
                    state_d = ARB_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ARB_RESP: begin
                last_d  = grant_q;
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State registers; last resets to 3 so requester 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            last_q  <= 2'd3;
            grant_q <= 2'd0;
            cnt_q   <= {CNT_W{1'b0}};
            err_q   <= 1'b0;
            rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_valid   = (state_q == ARB_BUSY);
    assign grant_valid = (state_q == ARB_BUSY) || (state_q == ARB_RESP);
    assign ack         = (state_q == ARB_RESP) ? onehot4(grant_q) : 4'b0000;
    assign grant       = grant_q;
    assign err         = err_q;
    assign rdata       = rdata_q;

    // Payload is steered through the registered grant and zeroed whenever the port is idle.
    assign mem_we    = mem_valid ? req_we[grant_q] : 1'b0;
    assign mem_addr  = mem_valid ? req_addr[int'(grant_q)*ADDR_W +: ADDR_W] : {ADDR_W{1'b0}};
    assign mem_wdata = mem_valid ? req_wdata[int'(grant_q)*DATA_W +: DATA_W] : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: picker table, directed corner sequences,
// and randomized traffic against a cycle-level transaction model.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req, req_we;
    logic [4*AW-1:0] req_addr;
    logic [4*DW-1:0] req_wdata;
    logic [3:0]      ack;
    logic            err;
    logic [DW-1:0]   rdata;
    logic [1:0]      grant;
    logic            grant_valid, mem_valid, mem_we, mem_ready;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;

    logic [3:0] t_req;
    logic [1:0] t_last, t_pick;
    logic       t_any;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata), .grant(grant),
        .grant_valid(grant_valid), .mem_valid(mem_valid), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    rr_pick4 u_pick (.req(t_req), .last(t_last), .pick(t_pick), .any(t_any));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_payload(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    function automatic int oh2i(input logic [3:0] oh);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (oh[i]) r = i;
        return r;
    endfunction

    // Winner = first requester in order last+1, last+2, last+3, last (mod 4).
    function automatic int rr_ref(input logic [3:0] r, input int last);
        int w;
        w = -1;
        for (int d = 4; d >= 1; d--) if (r[(last + d) % 4]) w = (last + d) % 4;
        return w;
    endfunction

    // Reference model: transaction owner, BUSY age, pending ack.
    int          m_owner = -1;
    int          m_age   = 0;
    int          m_ack   = -1;
    int          m_last  = 3;
    logic        m_err   = 1'b0;
    logic [31:0] m_rdata = 32'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_owner = -1; m_age = 0; m_ack = -1; m_last = 3;
            chk("rst_ack", ack, 64'd0);
            chk("rst_mem_valid", mem_valid, 64'd0);
            chk("rst_grant_valid", grant_valid, 64'd0);
            chk("rst_grant", grant, 64'd0);
            chk("rst_err", err, 64'd0);
            chk("rst_rdata", rdata, 64'd0);
            chk("rst_mem_addr", mem_addr, 64'd0);
            chk("rst_mem_we", mem_we, 64'd0);
            chk("rst_mem_wdata", mem_wdata, 64'd0);
        end else begin
            chk("mem_valid", mem_valid, 64'(m_owner >= 0));
            chk("grant_valid", grant_valid, 64'((m_owner >= 0) || (m_ack >= 0)));
            chk("ack", ack, (m_ack >= 0) ? 64'(4'b0001 << m_ack) : 64'd0);
            if (m_owner >= 0) begin
                chk("grant_busy", grant, 64'(m_owner));
                chk("mem_addr", mem_addr, 64'(req_addr[m_owner*AW +: AW]));
                chk("mem_wdata", mem_wdata, 64'(req_wdata[m_owner*DW +: DW]));
                chk("mem_we", mem_we, 64'(req_we[m_owner]));
            end else begin
                chk("mem_addr_idle", mem_addr, 64'd0);
                chk("mem_wdata_idle", mem_wdata, 64'd0);
                chk("mem_we_idle", mem_we, 64'd0);
            end
            if (m_ack >= 0) begin
                chk("grant_resp", grant, 64'(m_ack));
                chk("err", err, 64'(m_err));
                chk("rdata", rdata, 64'(m_rdata));
            end
            if (m_ack >= 0) begin
                m_last = m_ack;
                m_ack  = -1;
            end else if (m_owner >= 0) begin
                m_age++;
                if (mem_ready) begin
                    m_ack = m_owner; m_err = 1'b0; m_rdata = mem_rdata; m_owner = -1;
                end else if (m_age == TO) begin
                    m_ack = m_owner; m_err = 1'b1; m_rdata = 32'd0; m_owner = -1;
                end
            end else begin
                int w;
                w = rr_ref(req, m_last);
                if (w >= 0) begin
                    m_owner = w;
                    m_age   = 0;
                end
            end
        end
    end

    typedef struct {
        logic [3:0] r;
        logic [1:0] l;
        logic [1:0] p;
        logic       a;
    } pick_vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        pick_vec_t   vt[11];
        int          n, n_ack, acks_seen;
        int          gseq[5];
        int          cyc[5];
        logic [3:0]  last_ack;
        logic        stall;

        vt[0]  = '{4'b0000, 2'd3, 2'd0, 1'b0};
        vt[1]  = '{4'b0001, 2'd3, 2'd0, 1'b1};
        vt[2]  = '{4'b1111, 2'd3, 2'd0, 1'b1};
        vt[3]  = '{4'b1111, 2'd0, 2'd1, 1'b1};
        vt[4]  = '{4'b1111, 2'd1, 2'd2, 1'b1};
        vt[5]  = '{4'b1111, 2'd2, 2'd3, 1'b1};
        vt[6]  = '{4'b1010, 2'd3, 2'd1, 1'b1};
        vt[7]  = '{4'b1010, 2'd1, 2'd3, 1'b1};
        vt[8]  = '{4'b0001, 2'd0, 2'd0, 1'b1};
        vt[9]  = '{4'b0100, 2'd2, 2'd2, 1'b1};
        vt[10] = '{4'b1001, 2'd0, 2'd3, 1'b1};
        for (int i = 0; i < 11; i++) begin
            t_req = vt[i].r; t_last = vt[i].l;
            #1;
            chk($sformatf("pick_any[%0d]", i), t_any, vt[i].a);
            if (vt[i].a) chk($sformatf("pick[%0d]", i), t_pick, vt[i].p);
        end

        rst_n = 1'b0; req = 4'b0000; req_we = 4'b0000; req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_rdata = 32'd0;
        repeat (3) step();
        rst_n = 1'b1;

        // All four requesting with an always-ready port: 0,1,2,3,0 spaced 3 cycles.
        for (int i = 0; i < 4; i++) set_payload(i, 1'b0, 32'h1000 + 32'(i), 32'h0);
        req = 4'b1111; mem_ready = 1'b1; mem_rdata = 32'h55AA0000;
        acks_seen = 0;
        for (int t = 0; t < 40 && acks_seen < 5; t++) begin
            step();
            if (ack != 4'b0000) begin
                gseq[acks_seen] = oh2i(ack);
                cyc[acks_seen] = t;
                acks_seen++;
            end
        end
        chk("rr_ack_count", 64'(acks_seen), 64'd5);
        for (int k = 0; k < 5 && k < acks_seen; k++) begin
            chk($sformatf("rr_grant[%0d]", k), 64'(gseq[k]), 64'(k % 4));
            if (k > 0) chk($sformatf("rr_spacing[%0d]", k), 64'(cyc[k] - cyc[k-1]), 64'd3);
        end
        step(); req = 4'b0000;

        // Reset in the middle of the third transaction.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req = 4'b1111; mem_rdata = 32'h0BADF00D; n_ack = 0;
        for (int t = 0; t < 40 && n_ack < 2; t++) begin
            step();
            if (ack != 4'b0000) n_ack++;
        end
        chk("rst_seq_acks", 64'(n_ack), 64'd2);
        for (int t = 0; t < 10; t++) begin
            step();
            if (mem_valid) break;
        end
        chk("rst_seq_busy", mem_valid, 64'd1);
        chk("rst_seq_grant2", grant, 64'd2);
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", ack, 64'd0);
        chk("midrst_valid", mem_valid, 64'd0);
        chk("midrst_gv", grant_valid, 64'd0);
        chk("midrst_grant", grant, 64'd0);
        chk("midrst_err", err, 64'd0);
        chk("midrst_rdata", rdata, 64'd0);
        chk("midrst_addr", mem_addr, 64'd0);
        req = 4'b1010;
        step(); step();
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            step();
            if (grant_valid) break;
        end
        chk("post_rst_gv", grant_valid, 64'd1);
        chk("post_rst_grant", grant, 64'd1);
        for (int t = 0; t < 40; t++) begin
            if (ack != 4'b0000) break;
            step();
        end
        chk("post_rst_ack", ack, 64'b0010);
        step(); req = 4'b0000;
        step();

        // Single read from requester 0 with one-cycle latency.
        set_payload(0, 1'b0, 32'h100, 32'h0);
        req = 4'b0001; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("rd_idle_valid", mem_valid, 64'd0);
        step();
        chk("rd_valid", mem_valid, 64'd1);
        chk("rd_addr", mem_addr, 64'h100);
        chk("rd_we", mem_we, 64'd0);
        step();
        chk("rd_ack", ack, 64'b0001);
        chk("rd_rdata", rdata, 64'hDEADBEEF);
        chk("rd_err", err, 64'd0);
        step(); req = 4'b0000;

        // Write from requester 2.
        step();
        set_payload(2, 1'b1, 32'h200, 32'h12345678);
        req = 4'b0100;
        step();
        chk("wr_we", mem_we, 64'd1);
        chk("wr_wdata", mem_wdata, 64'h12345678);
        chk("wr_grant", grant, 64'd2);
        step();
        chk("wr_ack", ack, 64'b0100);
        step(); req = 4'b0000; req_we = 4'b0000;

        // Full timeout with the port never ready.
        step();
        req = 4'b0001; mem_ready = 1'b0;
        n = 0;
        for (int t = 0; t < 40; t++) begin
            step();
            if (mem_valid) n++;
            else break;
        end
        chk("to_valid_cycles", 64'(n), 64'(TO));
        chk("to_ack", ack, 64'b0001);
        chk("to_err", err, 64'd1);
        chk("to_rdata", rdata, 64'd0);
        step(); req = 4'b0000;

        // Ready arrives in the last BUSY cycle: completion wins.
        step();
        req = 4'b0010;
        step();
        for (int k = 1; k <= TO; k++) begin
            mem_ready = (k == TO);
            mem_rdata = 32'hCAFE0016;
            step();
        end
        chk("late_ack", ack, 64'b0010);
        chk("late_err", err, 64'd0);
        chk("late_rdata", rdata, 64'hCAFE0016);
        mem_ready = 1'b0;
        step(); req = 4'b0000;
        step();

        // Randomized traffic; requesters hold until acked, then may reissue.
        last_ack = 4'b0000; stall = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            step();
            if ((c % 200) == 199) stall = ~stall;
            for (int i = 0; i < 4; i++) begin
                if (last_ack[i]) req[i] = 1'b0;
                if (!req[i] && ($urandom % 3 == 0)) begin
                    set_payload(i, 1'($urandom), $urandom, $urandom);
                    req[i] = 1'b1;
                end
            end
            last_ack = ack;
            mem_ready = stall ? ($urandom % 20 == 0) : ($urandom % 4 != 0);
            mem_rdata = $urandom;
        end
        step(); req = 4'b0000;
        repeat (40) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
